// File: rtl/atm_light_estimator_if.sv
// AXI4-Stream pixel channel (RGB in TDATA[23:0]) into the atmospheric light estimator.
`timescale 1ns/1ps

interface atm_light_estimator_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (
    output TDATA,
    output TVALID,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    input  TLAST,
    output TREADY
  );
endinterface

// File: rtl/atm_light_estimator.sv
// Atmospheric light estimator: over one frame, keeps the RGB of the earliest
// pixel with the largest dark channel min(R,G,B).
// Optional macro ALE_TLAST_CHECK_EN: flags TLAST/frame-length disagreement and
// ends the pass early on a premature TLAST.
`timescale 1ns/1ps

module atm_light_estimator #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        start,
  atm_light_estimator_if.slave        S_AXIS,
  output logic [7:0]                  A_R,
  output logic [7:0]                  A_G,
  output logic [7:0]                  A_B,
  output logic                        done,
  output logic                        busy,
  output logic                        tlast_err
);

  localparam int unsigned FRAME_BEATS = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int unsigned PIX_W       = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Stage-1 payload: one accepted pixel with its dark value and first-beat tag
  typedef struct packed {
    logic [PIX_W-1:0] dark;
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic             first;
  } stage1_t;

  state_t           state;
  state_t           state_nxt;

  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_d;
  logic             busy_d;
  logic             done_d;

  logic [CNT_W-1:0] pix_cnt;
  logic             first_flag;
  stage1_t          s1;
  logic             s1_valid;
  logic [PIX_W-1:0] max_dark;
  logic [PIX_W-1:0] a_r_q;
  logic [PIX_W-1:0] a_g_q;
  logic [PIX_W-1:0] a_b_q;

  logic             accept;
  logic             arm;
  logic             cnt_at_last;
  logic             end_frame;
  logic [PIX_W-1:0] pix_r;
  logic [PIX_W-1:0] pix_g;
  logic [PIX_W-1:0] pix_b;
  logic [PIX_W-1:0] pix_dark;
  logic             s2_take;

  assign pix_r       = S_AXIS.TDATA[23:16];
  assign pix_g       = S_AXIS.TDATA[15:8];
  assign pix_b       = S_AXIS.TDATA[7:0];

  assign accept      = S_AXIS.TVALID & ready_q;
  assign arm         = start & ((state == IDLE) | (state == DONE));
  assign cnt_at_last = (pix_cnt == LAST_CNT);
  assign s2_take     = s1_valid & (s1.first | (s1.dark > max_dark));

`ifdef ALE_TLAST_CHECK_EN
  logic tlast_err_q;
  logic unused_tdata_hi;

  assign unused_tdata_hi = ^S_AXIS.TDATA[31:24];
  assign end_frame       = accept & (cnt_at_last | S_AXIS.TLAST);
  assign tlast_err       = tlast_err_q;

  // Sticky flag: accepted TLAST must coincide with the last beat of the frame
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tlast_err_q <= 1'b0;
    end else if (arm) begin
      tlast_err_q <= 1'b0;
    end else if (accept && (S_AXIS.TLAST != cnt_at_last)) begin
      tlast_err_q <= 1'b1;
    end
  end
`else
  logic unused_axis_bits;

  assign unused_axis_bits = ^{S_AXIS.TDATA[31:24], S_AXIS.TLAST};
  assign end_frame        = accept & cnt_at_last;
  assign tlast_err        = 1'b0;
`endif

  // Dark channel of the pixel currently on the bus
  always_comb begin
    pix_dark = pix_r;
    if (pix_g < pix_dark) pix_dark = pix_g;
    if (pix_b < pix_dark) pix_dark = pix_b;
  end

  // FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; start is only honoured from IDLE or DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (end_frame) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (start) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the registers track the state
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_nxt)
      ACCUM: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      DRAIN:   busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered handshake and status outputs
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Beat counter and first-beat marker, rearmed on every accepted start
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      pix_cnt    <= '0;
      first_flag <= 1'b0;
    end else if (arm) begin
      pix_cnt    <= '0;
      first_flag <= 1'b1;
    end else if (accept) begin
      pix_cnt    <= pix_cnt + CNT_W'(1);
      first_flag <= 1'b0;
    end
  end

  // Stage 1: capture the accepted pixel and its dark value
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1.dark  <= pix_dark;
        s1.r     <= pix_r;
        s1.g     <= pix_g;
        s1.b     <= pix_b;
        s1.first <= first_flag;
      end
    end
  end

  // Stage 2: keep the earliest pixel whose dark value is strictly the largest
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      max_dark <= '0;
      a_r_q    <= '0;
      a_g_q    <= '0;
      a_b_q    <= '0;
    end else if (s2_take) begin
      max_dark <= s1.dark;
      a_r_q    <= s1.r;
      a_g_q    <= s1.g;
      a_b_q    <= s1.b;
    end
  end

  assign S_AXIS.TREADY = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign A_R           = a_r_q;
  assign A_G           = a_g_q;
  assign A_B           = a_b_q;

endmodule
